// File: rtl/fixed_isqrt_pkg.sv
// Shared definitions for the fixed-point inverse-square-root datapath:
// seed-ROM entry function, zero-operand guess marker and the stage bundle type.
package fixed_isqrt_pkg;

   localparam int ISQRT_DEF_WIDTH     = 16;
   localparam int ISQRT_DEF_MSB_WIDTH = 4;

   localparam logic [63:0] ISQRT_ZERO_MARKER = '1;

   typedef struct packed {
      logic [ISQRT_DEF_WIDTH-1:0]     x_reduced;
      logic [ISQRT_DEF_WIDTH-1:0]     guess;
      logic [ISQRT_DEF_MSB_WIDTH-1:0] msb;
   } isqrt_bundle_t;

   // round(2^(width-1) / sqrt(1 + (i+0.5)/2^lutPow)) in pure integer arithmetic:
   // floor(sqrt(2^(2*width) * 2^(lutPow+1) / (2^(lutPow+1) + 2i + 1))) is floor(2y),
   // and (floor(2y) + 1) >> 1 is round(y).
   function automatic logic [63:0] isqrt_lut_entry(input int i, input int width, input int lutPow);
      logic [127:0] num;
      logic [127:0] den;
      logic [127:0] quo;
      logic [127:0] root;
      logic [127:0] trial;
      num  = 128'(1) << (2 * width + lutPow + 1);
      den  = (128'(1) << (lutPow + 1)) + 128'(2 * i + 1);
      quo  = num / den;
      root = '0;
      for (int b = 63; b >= 0; b--) begin
         trial = root | (128'(1) << b);
         if (trial * trial <= quo) begin
            root = trial;
         end
      end
      return 64'((root + 128'(1)) >> 1);
   endfunction

endpackage

// File: rtl/fixed_leading_one_detect.sv
// Combinational priority encoder: index of the highest set bit, plus an all-zero flag.
module fixed_leading_one_detect #(
   parameter int IN_WIDTH  = 16,
   parameter int MSB_WIDTH = 4
) (
   input  logic [IN_WIDTH-1:0]  i_data,
   output logic [MSB_WIDTH-1:0] o_msb,
   output logic                 o_zero
);

   always_comb begin
      o_msb = '0;
      for (int k = 0; k < IN_WIDTH; k++) begin
         if (i_data[k]) begin
            o_msb = MSB_WIDTH'(k);
         end
      end
   end

   assign o_zero = ~|i_data;

endmodule

// File: rtl/skid_buffer.sv
// Registered valid/ready slice with one skid entry; o_ready depends only on local state.
module skid_buffer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_data
);

   logic                  r_outValid;
   logic [DATA_WIDTH-1:0] r_outData;
   logic                  r_skidValid;
   logic [DATA_WIDTH-1:0] r_skidData;

   // The skid entry only fills when the output is stalled and upstream still had space.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_outValid  <= 1'b0;
         r_outData   <= '0;
         r_skidValid <= 1'b0;
         r_skidData  <= '0;
      end else if (!r_outValid || i_ready) begin
         if (r_skidValid) begin
            r_outValid  <= 1'b1;
            r_outData   <= r_skidData;
            r_skidValid <= 1'b0;
         end else begin
            r_outValid <= i_valid;
            if (i_valid) begin
               r_outData <= i_data;
            end
         end
      end else if (i_valid && !r_skidValid) begin
         r_skidValid <= 1'b1;
         r_skidData  <= i_data;
      end
   end

   assign o_ready = ~r_skidValid;
   assign o_valid = r_outValid;
   assign o_data  = r_outData;

endmodule

// File: rtl/fixed_isqrt_range_reduce.sv
// Range reduction front end: leading-one detect, normalise to Q1.(WIDTH-1), seed ROM lookup.
// Optional macro FIXED_ISQRT_ZERO_FLAG_EN adds data_out_zero and makes the zero-case guess 0.
module fixed_isqrt_range_reduce
   import fixed_isqrt_pkg::*;
#(
   parameter int IN_WIDTH  = 16,
   parameter int WIDTH     = 16,
   parameter int LUT_POW   = 5,
   parameter int MSB_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IN_WIDTH-1:0]  data_in,
   input  logic                 data_in_valid,
   output logic                 data_in_ready,
   output logic [WIDTH-1:0]     data_out_x_reduced,
   output logic [WIDTH-1:0]     data_out_guess,
   output logic [MSB_WIDTH-1:0] data_out_msb,
   output logic                 data_out_valid,
   input  logic                 data_out_ready
`ifdef FIXED_ISQRT_ZERO_FLAG_EN
   ,
   output logic                 data_out_zero
`endif
);

   localparam int ROM_DEPTH = 1 << LUT_POW;
   localparam int S1W       = IN_WIDTH + MSB_WIDTH + 1;
   localparam int S2W       = WIDTH + MSB_WIDTH + 1;
`ifdef FIXED_ISQRT_ZERO_FLAG_EN
   localparam int S3W       = 2 * WIDTH + MSB_WIDTH + 1;
   localparam logic [WIDTH-1:0] ZERO_GUESS = '0;
`else
   localparam int S3W       = 2 * WIDTH + MSB_WIDTH;
   localparam logic [WIDTH-1:0] ZERO_GUESS = ISQRT_ZERO_MARKER[WIDTH-1:0];
`endif

   if (MSB_WIDTH != $clog2(IN_WIDTH)) begin : g_badMsbWidth
      $error("MSB_WIDTH must equal $clog2(IN_WIDTH)");
   end
   if (IN_WIDTH < 2) begin : g_badInWidth
      $error("IN_WIDTH must be at least 2");
   end
   if (LUT_POW > WIDTH - 1) begin : g_badLutPow
      $error("LUT_POW must not exceed WIDTH-1");
   end

   logic [MSB_WIDTH-1:0] w_lodMsb;
   logic                 w_lodZero;
   logic                 w_s1InReady;
   logic                 w_s1Valid;
   logic                 w_s1Ready;
   logic [S1W-1:0]       w_s1Data;
   logic [IN_WIDTH-1:0]  w_s1Operand;
   logic [MSB_WIDTH-1:0] w_s1Msb;
   logic                 w_s1Zero;
   logic [MSB_WIDTH-1:0] w_shiftAmt;
   logic [IN_WIDTH-1:0]  w_shifted;
   logic [WIDTH-1:0]     w_xReduced;
   logic                 w_s2Valid;
   logic                 w_s2Ready;
   logic [S2W-1:0]       w_s2Data;
   logic [WIDTH-1:0]     w_s2X;
   logic [MSB_WIDTH-1:0] w_s2Msb;
   logic                 w_s2Zero;
   logic [LUT_POW-1:0]   w_romIndex;
   logic [WIDTH-1:0]     w_rom [ROM_DEPTH];
   logic [WIDTH-1:0]     w_guess;
   logic [S3W-1:0]       w_s3InData;
   logic [S3W-1:0]       w_s3Data;

   // Stage 1: leading-one detect, registered together with the raw operand.
   fixed_leading_one_detect #(
      .IN_WIDTH (IN_WIDTH),
      .MSB_WIDTH(MSB_WIDTH)
   ) u_lod (
      .i_data(data_in),
      .o_msb (w_lodMsb),
      .o_zero(w_lodZero)
   );

   skid_buffer #(.DATA_WIDTH(S1W)) u_s1 (
      .clk    (clk),
      .rst    (rst),
      .i_valid(data_in_valid),
      .o_ready(w_s1InReady),
      .i_data ({data_in, w_lodMsb, w_lodZero}),
      .o_valid(w_s1Valid),
      .i_ready(w_s1Ready),
      .o_data (w_s1Data)
   );

   assign data_in_ready = w_s1InReady & ~rst;
   assign {w_s1Operand, w_s1Msb, w_s1Zero} = w_s1Data;

   // Stage 2: shift the leading one up to the top bit, then fit to WIDTH bits.
   assign w_shiftAmt = MSB_WIDTH'(IN_WIDTH - 1) - w_s1Msb;
   assign w_shifted  = w_s1Operand << w_shiftAmt;

   if (IN_WIDTH >= WIDTH) begin : g_truncate
      assign w_xReduced = w_shifted[IN_WIDTH-1 -: WIDTH];
   end else begin : g_pad
      assign w_xReduced = {w_shifted, {(WIDTH - IN_WIDTH){1'b0}}};
   end

   skid_buffer #(.DATA_WIDTH(S2W)) u_s2 (
      .clk    (clk),
      .rst    (rst),
      .i_valid(w_s1Valid),
      .o_ready(w_s1Ready),
      .i_data ({w_xReduced, w_s1Msb, w_s1Zero}),
      .o_valid(w_s2Valid),
      .i_ready(w_s2Ready),
      .o_data (w_s2Data)
   );

   assign {w_s2X, w_s2Msb, w_s2Zero} = w_s2Data;

   // Stage 3: seed lookup indexed by the leading fraction bits below the integer bit.
   for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
      localparam logic [63:0] ENTRY = isqrt_lut_entry(gi, WIDTH, LUT_POW);
      assign w_rom[gi] = ENTRY[WIDTH-1:0];
   end

   assign w_romIndex = w_s2X[WIDTH-2 -: LUT_POW];
   assign w_guess    = w_s2Zero ? ZERO_GUESS : w_rom[w_romIndex];

`ifdef FIXED_ISQRT_ZERO_FLAG_EN
   assign w_s3InData = {w_s2X, w_guess, w_s2Msb, w_s2Zero};
   assign {data_out_x_reduced, data_out_guess, data_out_msb, data_out_zero} = w_s3Data;
`else
   assign w_s3InData = {w_s2X, w_guess, w_s2Msb};
   assign {data_out_x_reduced, data_out_guess, data_out_msb} = w_s3Data;
`endif

   skid_buffer #(.DATA_WIDTH(S3W)) u_s3 (
      .clk    (clk),
      .rst    (rst),
      .i_valid(w_s2Valid),
      .o_ready(w_s2Ready),
      .i_data (w_s3InData),
      .o_valid(data_out_valid),
      .i_ready(data_out_ready),
      .o_data (w_s3Data)
   );

endmodule

// File: tb/tb_fixed_isqrt_range_reduce.sv
// Self-checking bench for fixed_isqrt_range_reduce: real-valued reference model, queue scoreboard,
// directed latency/boundary cases, stall, throughput, random traffic and mid-stream reset.
module tb_fixed_isqrt_range_reduce;

   localparam int IN  = 16;
   localparam int W   = 16;
   localparam int P   = 5;
   localparam int MW  = 4;

   typedef struct {
      int     msb;
      longint xr;
      longint guess;
      bit     zero;
   } expT;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [IN-1:0] dataIn = '0;
   logic          dataInValid = 1'b0;
   logic          data_in_ready;
   logic [W-1:0]  data_out_x_reduced;
   logic [W-1:0]  data_out_guess;
   logic [MW-1:0] data_out_msb;
   logic          data_out_valid;
   logic          dataOutReady = 1'b1;
`ifdef FIXED_ISQRT_ZERO_FLAG_EN
   logic          data_out_zero;
`endif

   int     checkCount = 0;
   int     passCount  = 0;
   int     cyc        = 0;
   int     readyMode  = 0;
   int     stallBase  = 0;
   int     outCount   = 0;
   int     markCount  = 0;
   int     firstCyc   = 0;
   int     lastCyc    = 0;
   expT    q[$];
   expT    popped;
   bit     prevStall  = 1'b0;
   longint heldX, heldG, heldM;

   fixed_isqrt_range_reduce #(
      .IN_WIDTH (IN),
      .WIDTH    (W),
      .LUT_POW  (P),
      .MSB_WIDTH(MW)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .data_in           (dataIn),
      .data_in_valid     (dataInValid),
      .data_in_ready     (data_in_ready),
      .data_out_x_reduced(data_out_x_reduced),
      .data_out_guess    (data_out_guess),
      .data_out_msb      (data_out_msb),
      .data_out_valid    (data_out_valid),
      .data_out_ready    (dataOutReady)
`ifdef FIXED_ISQRT_ZERO_FLAG_EN
      ,
      .data_out_zero     (data_out_zero)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checkCount++;
      if (actual == expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Reference: msb = floor(log2 d), normalise, then the real-valued 1/sqrt at the bin centre.
   function automatic expT modelOf(input longint d);
      expT    e;
      longint s;
      int     idx;
      real    g;
      e.zero = (d == 0);
      e.msb  = 0;
      for (longint t = d; t > 1; t = t >> 1) e.msb++;
      if (e.zero) begin
         e.xr = 0;
`ifdef FIXED_ISQRT_ZERO_FLAG_EN
         e.guess = 0;
`else
         e.guess = (longint'(1) << W) - 1;
`endif
      end else begin
         s = d << (IN - 1 - e.msb);
         if (IN >= W) e.xr = s >> (IN - W);
         else         e.xr = s << (W - IN);
         idx = int'((e.xr >> (W - 1 - P)) % (longint'(1) << P));
         g = (2.0 ** (W - 1)) / $sqrt(1.0 + (idx + 0.5) / (2.0 ** P));
         e.guess = longint'($rtoi(g + 0.5));
      end
      return e;
   endfunction

   // Output-ready pattern: 0 = always ready, 1 = random 70%, 2 = stalled for cycles 4..8 of a stream.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      case (readyMode)
         1:       dataOutReady = ($urandom_range(0, 99) < 70);
         2:       dataOutReady = !((cyc - stallBase) >= 4 && (cyc - stallBase) <= 8);
         default: dataOutReady = 1'b1;
      endcase
   end

   // Scoreboard: push on input handshake, pop and compare on output handshake, hold check on stall.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         prevStall = 1'b0;
      end else begin
         if (prevStall) begin
            checkOutput("hold_valid", data_out_valid, 1);
            checkOutput("hold_x", data_out_x_reduced, heldX);
            checkOutput("hold_guess", data_out_guess, heldG);
            checkOutput("hold_msb", data_out_msb, heldM);
         end
         if (data_out_valid && dataOutReady) begin
            checkOutput("item_expected", longint'(q.size() != 0), 1);
            if (q.size() != 0) begin
               popped = q.pop_front();
               checkOutput("out_msb", data_out_msb, popped.msb);
               checkOutput("out_x_reduced", data_out_x_reduced, popped.xr);
               checkOutput("out_guess", data_out_guess, popped.guess);
`ifdef FIXED_ISQRT_ZERO_FLAG_EN
               checkOutput("out_zero", data_out_zero, popped.zero);
`endif
               if (outCount == markCount) firstCyc = cyc;
               lastCyc  = cyc;
               outCount = outCount + 1;
            end
         end
         prevStall = data_out_valid && !dataOutReady;
         heldX = data_out_x_reduced;
         heldG = data_out_guess;
         heldM = data_out_msb;
         if (dataInValid && data_in_ready) q.push_back(modelOf(dataIn));
      end
   end

   // Entered and left at posedge+1; holds valid until accepted, bounded.
   task automatic applyStimulus(input logic [IN-1:0] v, output int stalls);
      bit acc;
      stalls = 0;
      dataIn = v;
      dataInValid = 1'b1;
      forever begin
         @(negedge clk);
         acc = data_in_ready;
         @(posedge clk);
         #1;
         if (acc) break;
         stalls++;
         if (stalls > 500) begin
            checkOutput("input_accept_timeout", stalls, 0);
            break;
         end
      end
      dataInValid = 1'b0;
   endtask

   task automatic sendAndCapture(input logic [IN-1:0] v, output int lat,
                                 output longint x, output longint g, output longint m);
      int stalls;
      applyStimulus(v, stalls);
      lat = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (data_out_valid) break;
         @(posedge clk);
         lat++;
      end
      x = data_out_x_reduced;
      g = data_out_guess;
      m = data_out_msb;
      @(posedge clk);
      #1;
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (q.size() == 0 && !data_out_valid) break;
      end
      checkOutput("drain_empty", q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      expT    pin;
      int     lat, stalls, stallTotal, gap, staleCnt;
      longint x, g, m;

      @(posedge clk);
      @(negedge clk);
      checkOutput("reset_out_valid", data_out_valid, 0);
      checkOutput("reset_x", data_out_x_reduced, 0);
      checkOutput("reset_guess", data_out_guess, 0);
      checkOutput("reset_msb", data_out_msb, 0);
      checkOutput("reset_in_ready", data_in_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_reset_in_ready", data_in_ready, 1);
      @(posedge clk);
      #1;

      pin = modelOf(1);
      checkOutput("model_one_x", pin.xr, 32768);
      checkOutput("model_one_guess", pin.guess, 32515);
      pin = modelOf(3);
      checkOutput("model_three_guess", pin.guess, 26617);
      checkOutput("model_three_msb", pin.msb, 1);
      pin = modelOf(0);
`ifdef FIXED_ISQRT_ZERO_FLAG_EN
      checkOutput("model_zero_guess", pin.guess, 0);
`else
      checkOutput("model_zero_guess", pin.guess, 65535);
`endif

      sendAndCapture(16'h0001, lat, x, g, m);
      checkOutput("lat_one", lat, 3);
      checkOutput("one_x", x, 32'h8000);
      checkOutput("one_guess", g, 32'h7F03);
      checkOutput("one_msb", m, 0);
      sendAndCapture(16'h0003, lat, x, g, m);
      checkOutput("lat_three", lat, 3);
      checkOutput("three_x", x, 32'hC000);
      checkOutput("three_guess", g, 26617);
      checkOutput("three_msb", m, 1);
      sendAndCapture(16'hFFFF, lat, x, g, m);
      checkOutput("ffff_x", x, 32'hFFFF);
      checkOutput("ffff_msb", m, 15);
      sendAndCapture(16'h0000, lat, x, g, m);
      checkOutput("zero_x", x, 0);
      checkOutput("zero_msb", m, 0);
`ifdef FIXED_ISQRT_ZERO_FLAG_EN
      checkOutput("zero_guess", g, 0);
`else
      checkOutput("zero_guess", g, 32'hFFFF);
`endif

      markCount = outCount;
      stallTotal = 0;
      stallBase = cyc;
      readyMode = 2;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(16'(i * 4099 + 7), stalls);
         stallTotal += stalls;
      end
      waitDrain();
      readyMode = 0;
      checkOutput("stall_in_ready_dropped", longint'(stallTotal > 0), 1);
      checkOutput("stall_all_out", outCount - markCount, 8);

      markCount = outCount;
      stallTotal = 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(16'($urandom), stalls);
         stallTotal += stalls;
      end
      waitDrain();
      checkOutput("tput_no_input_stall", stallTotal, 0);
      checkOutput("tput_out_count", outCount - markCount, 20);
      checkOutput("tput_span", lastCyc - firstCyc, 19);

      readyMode = 1;
      for (int i = 0; i < 10000; i++) begin
         gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
         applyStimulus(16'($urandom) >> $urandom_range(0, 16), stalls);
      end
      readyMode = 0;
      waitDrain();

      for (int i = 0; i < 3; i++) applyStimulus(16'(i + 9), stalls);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_in_ready", data_in_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_out_valid", data_out_valid, 0);
      checkOutput("midrst_in_ready_after", data_in_ready, 1);
      staleCnt = 0;
      repeat (8) begin
         @(posedge clk);
         @(negedge clk);
         if (data_out_valid) staleCnt++;
      end
      checkOutput("midrst_no_stale", staleCnt, 0);
      @(posedge clk);
      #1;
      sendAndCapture(16'h0005, lat, x, g, m);
      checkOutput("midrst_next_latency", lat, 3);
      checkOutput("midrst_next_x", x, 32'hA000);
      waitDrain();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
